// File: rtl/hex_display_pkg.sv
// Shared constants for the multiplexed hex display scanner.
// Active-low segment patterns {a,b,c,d,e,f,g} and the digit-count limit.
package hex_display_pkg;

  localparam int MAX_DIGITS = 8;

  localparam logic [6:0] SEG_0     = 7'b0000001;
  localparam logic [6:0] SEG_1     = 7'b1001111;
  localparam logic [6:0] SEG_2     = 7'b0010010;
  localparam logic [6:0] SEG_3     = 7'b0000110;
  localparam logic [6:0] SEG_4     = 7'b1001100;
  localparam logic [6:0] SEG_5     = 7'b0100100;
  localparam logic [6:0] SEG_6     = 7'b0100000;
  localparam logic [6:0] SEG_7     = 7'b0001111;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0001100;
  localparam logic [6:0] SEG_A     = 7'b0001000;
  localparam logic [6:0] SEG_B     = 7'b1100000;
  localparam logic [6:0] SEG_C     = 7'b0110001;
  localparam logic [6:0] SEG_D     = 7'b1000010;
  localparam logic [6:0] SEG_E     = 7'b0110000;
  localparam logic [6:0] SEG_F     = 7'b0111000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

endpackage

// File: rtl/hex_seg_decode.sv
// Combinational nibble to active-low 7-segment decoder.
// Ports: nib (4-bit hex digit in), seg (7-bit {a..g} out, active-low).
module hex_seg_decode
  import hex_display_pkg::*;
(
  input  logic [3:0] nib,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    unique case (nib)
      4'h0: seg = SEG_0;
      4'h1: seg = SEG_1;
      4'h2: seg = SEG_2;
      4'h3: seg = SEG_3;
      4'h4: seg = SEG_4;
      4'h5: seg = SEG_5;
      4'h6: seg = SEG_6;
      4'h7: seg = SEG_7;
      4'h8: seg = SEG_8;
      4'h9: seg = SEG_9;
      4'hA: seg = SEG_A;
      4'hB: seg = SEG_B;
      4'hC: seg = SEG_C;
      4'hD: seg = SEG_D;
      4'hE: seg = SEG_E;
      4'hF: seg = SEG_F;
    endcase
  end

endmodule

// File: rtl/hex_display_scan.sv
// Multiplexed hex display driver with static per-digit outputs.
// Ports: clk, rst (sync, active-high), enable, load, value, dp_in,
//   blank_lz in; seg, dp, an (scanned, active-low), hex_flat out.
module hex_display_scan
  import hex_display_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int SCAN_DIV   = 50000
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      enable,
  input  logic                      load,
  input  logic [4*NUM_DIGITS-1:0]   value,
  input  logic [NUM_DIGITS-1:0]     dp_in,
  input  logic                      blank_lz,
  output logic [6:0]                seg,
  output logic                      dp,
  output logic [NUM_DIGITS-1:0]     an,
  output logic [7*NUM_DIGITS-1:0]   hex_flat
);

  localparam int IDX_W =
    (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int PRE_W = $clog2(SCAN_DIV);
  localparam logic [IDX_W-1:0] IDX_LAST =
    IDX_W'(NUM_DIGITS - 1);
  localparam logic [PRE_W-1:0] PRE_LAST =
    PRE_W'(SCAN_DIV - 1);

  logic [4*NUM_DIGITS-1:0] val_q, val_d;
  logic [NUM_DIGITS-1:0]   dpl_q, dpl_d;
  logic [PRE_W-1:0]        presc_q, presc_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [NUM_DIGITS-1:0]   an_q, an_d;
  logic [6:0]              seg_q, seg_d;
  logic                    dp_q, dp_d;
  logic [7*NUM_DIGITS-1:0] flat_q, flat_d;
  logic [7*NUM_DIGITS-1:0] flat_rst;

  logic [NUM_DIGITS-1:0]   blank;
  logic                    lz_nz;
  logic [6:0]              dig_seg [NUM_DIGITS];
  logic [3:0]              scan_nib;
  logic [6:0]              scan_seg;

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_dig
    hex_seg_decode u_dig (
      .nib (val_q[4*g +: 4]),
      .seg (dig_seg[g])
    );
  end

  hex_seg_decode u_scan (
    .nib (scan_nib),
    .seg (scan_seg)
  );

  // Walk from the top digit down; a digit is a leading
  // zero while no nonzero nibble has been seen above it.
  always_comb begin
    lz_nz = 1'b0;
    blank = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      lz_nz    = lz_nz | (val_q[4*i +: 4] != 4'h0);
      blank[i] = blank_lz && (i != 0) && !lz_nz;
    end
  end

  always_comb begin
    flat_d   = '0;
    flat_rst = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      flat_d[7*i +: 7] = blank[i] ? SEG_BLANK
                                  : dig_seg[i];
      flat_rst[7*i +: 7] = (blank_lz && i != 0)
                           ? SEG_BLANK : SEG_0;
    end
  end

  assign scan_nib = val_q[4*int'(idx_q) +: 4];

  always_comb begin
    val_d   = load ? value : val_q;
    dpl_d   = load ? dp_in : dpl_q;
    presc_d = presc_q;
    idx_d   = idx_q;
    an_d    = '1;
    seg_d   = SEG_BLANK;
    dp_d    = 1'b1;
    if (enable) begin
      an_d  = ~(NUM_DIGITS'(1) << idx_q);
      seg_d = blank[idx_q] ? SEG_BLANK : scan_seg;
      dp_d  = ~dpl_q[idx_q];
      if (presc_q == PRE_LAST) begin
        presc_d = '0;
        idx_d   = (idx_q == IDX_LAST) ? '0
                                      : idx_q + 1'b1;
      end else begin
        presc_d = presc_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      val_q   <= '0;
      dpl_q   <= '0;
      presc_q <= '0;
      idx_q   <= '0;
      an_q    <= '1;
      seg_q   <= SEG_BLANK;
      dp_q    <= 1'b1;
      flat_q  <= flat_rst;
    end else begin
      val_q   <= val_d;
      dpl_q   <= dpl_d;
      presc_q <= presc_d;
      idx_q   <= idx_d;
      an_q    <= an_d;
      seg_q   <= seg_d;
      dp_q    <= dp_d;
      flat_q  <= flat_d;
    end
  end

  assign an       = an_q;
  assign seg      = seg_q;
  assign dp       = dp_q;
  assign hex_flat = flat_q;

endmodule

// File: tb/tb_hex_display_scan.sv
// Self-checking bench for hex_display_scan (4 digits, dwell 4).
// Reference model plus directed literal checks.
module tb_hex_display_scan;

  localparam int ND = 4;
  localparam int SD = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic        load;
  logic [15:0] value;
  logic [3:0]  dp_in;
  logic        blank_lz;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;
  logic [27:0] hex_flat;

  int n_chk  = 0;
  int n_pass = 0;

  hex_display_scan #(
    .NUM_DIGITS (ND),
    .SCAN_DIV   (SD)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .enable   (enable),
    .load     (load),
    .value    (value),
    .dp_in    (dp_in),
    .blank_lz (blank_lz),
    .seg      (seg),
    .dp       (dp),
    .an       (an),
    .hex_flat (hex_flat)
  );

  always #5 clk = ~clk;

  logic [6:0] tbl [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0001100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };

  function automatic logic [6:0] mseg(
    input logic [15:0] v, input int i, input logic bl);
    logic [15:0] above;
    above = v >> (4 * i);
    if (bl && i > 0 && above == 16'h0)
      return 7'b1111111;
    return tbl[above & 16'hF];
  endfunction

  function automatic logic [27:0] mflat(
    input logic [15:0] v, input logic bl);
    logic [27:0] r;
    r = '0;
    for (int i = 0; i < ND; i++)
      r[7*i +: 7] = mseg(v, i, bl);
    return r;
  endfunction

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h",
                  nm, act, exp);
  endtask

  // Model: one counter of enabled cycles stands in for
  // the scan position; outputs use pre-edge data.
  logic [15:0] m_val;
  logic [3:0]  m_dp;
  int          m_cnt;
  bit          m_valid = 1'b0;
  logic [3:0]  e_an;
  logic [6:0]  e_seg;
  logic        e_dp;
  logic [27:0] e_flat;

  initial forever begin
    @(posedge clk);
    if (rst) begin
      m_val   = '0;
      m_dp    = '0;
      m_cnt   = 0;
      e_an    = 4'hF;
      e_seg   = 7'h7F;
      e_dp    = 1'b1;
      e_flat  = mflat(16'h0, blank_lz);
      m_valid = 1'b1;
    end else begin
      int d;
      e_flat = mflat(m_val, blank_lz);
      if (enable) begin
        d     = m_cnt / SD;
        e_an  = ~(4'b0001 << d);
        e_seg = mseg(m_val, d, blank_lz);
        e_dp  = ~m_dp[d];
        m_cnt = (m_cnt + 1) % (ND * SD);
      end else begin
        e_an  = 4'hF;
        e_seg = 7'h7F;
        e_dp  = 1'b1;
      end
      if (load) begin
        m_val = value;
        m_dp  = dp_in;
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (m_valid) begin
      chk("m_an", an, e_an);
      chk("m_seg", seg, e_seg);
      chk("m_dp", dp, e_dp);
      chk("m_flat", hex_flat, e_flat);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [3:0] an_seq  [4] = '{4'b1110, 4'b1101,
                              4'b1011, 4'b0111};
  logic [6:0] seg_seq [4] = '{7'b0111000, 7'b0001000,
                              7'b0010010, 7'b1001111};

  initial begin
    int w;
    rst = 1'b1; enable = 1'b0; load = 1'b0;
    value = '0; dp_in = '0; blank_lz = 1'b0;
    tick(); tick();
    chk("rst_an", an, 4'hF);
    chk("rst_seg", seg, 7'h7F);
    chk("rst_dp", dp, 1'b1);
    chk("rst_flat", hex_flat, {4{7'b0000001}});

    // Load 12AF while idle, then scan.
    rst = 1'b0; load = 1'b1; value = 16'h12AF;
    tick();
    load = 1'b0;
    tick();
    chk("flat_12af", hex_flat,
        {7'b1001111, 7'b0010010, 7'b0001000, 7'b0111000});
    chk("idle_an", an, 4'hF);
    enable = 1'b1;
    tick();
    for (int k = 0; k < 4; k++) begin
      chk("scan_an", an, an_seq[k]);
      chk("scan_seg", seg, seg_seq[k]);
      if (k < 3) repeat (SD) tick();
    end

    // Leading-zero blanking.
    value = 16'h0050; blank_lz = 1'b1; load = 1'b1;
    tick();
    load = 1'b0;
    tick();
    chk("flat_0050", hex_flat,
        {7'h7F, 7'h7F, 7'b0100100, 7'b0000001});
    for (int k = 0; k < 16; k++) begin
      tick();
      if (an == 4'b1011 || an == 4'b0111)
        chk("lz_scan_seg", seg, 7'h7F);
    end

    // All-zero value: digit 0 stays, dp survives blanking.
    value = 16'h0000; dp_in = 4'b0100; load = 1'b1;
    tick();
    load = 1'b0;
    tick();
    chk("flat_0000", hex_flat,
        {7'h7F, 7'h7F, 7'h7F, 7'b0000001});
    for (int k = 0; k < 16; k++) begin
      tick();
      if (an == 4'b1110) begin
        chk("z_d0_seg", seg, 7'b0000001);
        chk("z_d0_dp", dp, 1'b1);
      end
      if (an == 4'b1011) begin
        chk("z_d2_seg", seg, 7'h7F);
        chk("z_d2_dp", dp, 1'b0);
      end
    end

    // Pause mid-dwell on digit 2.
    value = 16'h12AF; dp_in = 4'b0000; blank_lz = 1'b0;
    load = 1'b1;
    tick();
    load = 1'b0;
    w = 0;
    while (an !== 4'b1011 && w < 20) begin
      tick(); w++;
    end
    chk("reach_idx2", an, 4'b1011);
    tick();
    enable = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick();
      chk("pause_an", an, 4'hF);
      chk("pause_seg", seg, 7'h7F);
    end
    enable = 1'b1;
    tick();
    chk("resume_an1", an, 4'b1011);
    chk("resume_seg", seg, 7'b0010010);
    tick();
    chk("resume_an2", an, 4'b1011);
    tick();
    chk("resume_next", an, 4'b0111);

    // Reset during digit 3 beats a simultaneous load.
    w = 0;
    while (an !== 4'b0111 && w < 20) begin
      tick(); w++;
    end
    chk("reach_idx3", an, 4'b0111);
    rst = 1'b1; load = 1'b1; value = 16'hFFFF;
    tick();
    chk("mrst_an", an, 4'hF);
    chk("mrst_seg", seg, 7'h7F);
    chk("mrst_flat", hex_flat, {4{7'b0000001}});
    rst = 1'b0; load = 1'b0;
    tick();
    chk("post_rst_an", an, 4'b1110);
    chk("post_rst_seg", seg, 7'b0000001);

    // Input changes without load are ignored.
    value = 16'h1234; load = 1'b1;
    tick();
    load = 1'b0;
    tick();
    value = 16'hABCD; dp_in = 4'hF;
    for (int k = 0; k < 20; k++) begin
      tick();
      chk("hold_flat", hex_flat,
          {7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100});
    end

    tick();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
